fp_add_prealign: RTL

- Parametrised two-stage pipelined front end for the floating-point adder.
- Takes two packed IEEE-754-style operands and an add/sub mode, and unpacks them with correct subnormal handling.
- Orders the operands by magnitude, classifies special values, and right-aligns the smaller significand with guard/round/sticky bits.
- Sits between the operand source and the significand add/normalise stages, with valid/ready handshaking on both sides.

---
 rtl/fp_add_prealign.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/fp_add_prealign.sv
// Floating-point adder front end: unpacks and orders two operands, classifies
// special results, then right-aligns the smaller significand with G/R/S bits.
module fp_add_prealign #(
   parameter  int EXP_W = 8,
   parameter  int MAN_W = 23,
   localparam int W     = 1 + EXP_W + MAN_W,
   localparam int SIG_W = MAN_W + 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic             op_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SIG_W-1:0] sig_big,
   output logic [SIG_W-1:0] sig_small,
   output logic [EXP_W-1:0] exp_big,
   output logic             sign_big,
   output logic             eff_sub,
   output logic             swapped,
   output logic [1:0]       special,
   output logic             special_sign
);

   typedef enum logic [1:0] {
      SP_NORMAL = 2'b00,
      SP_NAN    = 2'b01,
      SP_INF    = 2'b10,
      SP_ZERO   = 2'b11
   } special_e;

   localparam logic [EXP_W-1:0] EXP_ONES = '1;

   // Stage 1 combinational: unpack, classify, order
   logic             sign_a, sign_b;
   logic [EXP_W-1:0] fexp_a, fexp_b, eexp_a, eexp_b;
   logic [MAN_W-1:0] frac_a, frac_b;
   logic [MAN_W:0]   sig_a, sig_b;
   logic             a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

   logic [MAN_W:0]   s1_sig_big_d, s1_sig_small_d;
   logic [EXP_W-1:0] s1_exp_big_d, s1_exp_small_d, s1_exp_diff_d;
   logic             s1_sign_big_d, s1_eff_sub_d, s1_swapped_d, s1_special_sign_d;
   special_e         s1_special_d;

   // Stage 1 registers
   logic             s1_valid_q;
   logic [MAN_W:0]   s1_sig_big_q, s1_sig_small_q;
   logic [EXP_W-1:0] s1_exp_big_q, s1_exp_diff_q;
   logic             s1_sign_big_q, s1_eff_sub_q, s1_swapped_q, s1_special_sign_q;
   special_e         s1_special_q;

   // Stage 2 align and output registers
   logic [SIG_W-1:0] ext_small, shifted, lost_mask, sig_small_d;
   logic             s2_can_load;
   logic             out_valid_q;
   logic [SIG_W-1:0] sig_big_q, sig_small_q;
   logic [EXP_W-1:0] exp_big_q;
   logic             sign_big_q, eff_sub_q, swapped_q, special_sign_q;
   special_e         special_q;

   assign s2_can_load = !out_valid_q || out_ready;
   // NOTE: in_ready is gated by rst_n so no pair is accepted on a reset edge.
   assign in_ready    = rst_n && (!s1_valid_q || s2_can_load);

   // NOTE: every variable gets a default at the top so no path infers a latch.
   always_comb begin
      sign_a = a[W-1];
      sign_b = b[W-1] ^ op_sub;
      fexp_a = a[W-2 -: EXP_W];
      fexp_b = b[W-2 -: EXP_W];
      frac_a = a[MAN_W-1:0];
      frac_b = b[MAN_W-1:0];
      eexp_a = (fexp_a == '0) ? EXP_W'(1) : fexp_a;
      eexp_b = (fexp_b == '0) ? EXP_W'(1) : fexp_b;
      sig_a  = {(fexp_a != '0), frac_a};
      sig_b  = {(fexp_b != '0), frac_b};
      a_nan  = (fexp_a == EXP_ONES) && (frac_a != '0);
      b_nan  = (fexp_b == EXP_ONES) && (frac_b != '0);
      a_inf  = (fexp_a == EXP_ONES) && (frac_a == '0);
      b_inf  = (fexp_b == EXP_ONES) && (frac_b == '0);
      a_zero = (fexp_a == '0) && (frac_a == '0);
      b_zero = (fexp_b == '0) && (frac_b == '0);

      s1_swapped_d   = 1'b0;
      s1_sig_big_d   = sig_a;
      s1_sig_small_d = sig_b;
      s1_exp_big_d   = eexp_a;
      s1_exp_small_d = eexp_b;
      s1_sign_big_d  = sign_a;
      // Ties keep A as the big operand.
      if (a[W-2:0] < b[W-2:0]) begin
         s1_swapped_d   = 1'b1;
         s1_sig_big_d   = sig_b;
         s1_sig_small_d = sig_a;
         s1_exp_big_d   = eexp_b;
         s1_exp_small_d = eexp_a;
         s1_sign_big_d  = sign_b;
      end
      s1_exp_diff_d = s1_exp_big_d - s1_exp_small_d;
      s1_eff_sub_d  = sign_a ^ sign_b;

      s1_special_d      = SP_NORMAL;
      s1_special_sign_d = 1'b0;
      if (a_nan || b_nan || (a_inf && b_inf && (sign_a != sign_b))) begin
         s1_special_d = SP_NAN;
      end else if (a_inf || b_inf) begin
         s1_special_d      = SP_INF;
         s1_special_sign_d = a_inf ? sign_a : sign_b;
      end else if (a_zero && b_zero) begin
         s1_special_d      = SP_ZERO;
         s1_special_sign_d = sign_a & sign_b;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q        <= 1'b0;
         s1_sig_big_q      <= '0;
         s1_sig_small_q    <= '0;
         s1_exp_big_q      <= '0;
         s1_exp_diff_q     <= '0;
         s1_sign_big_q     <= 1'b0;
         s1_eff_sub_q      <= 1'b0;
         s1_swapped_q      <= 1'b0;
         s1_special_q      <= SP_NORMAL;
         s1_special_sign_q <= 1'b0;
      end else begin
         if (in_ready) s1_valid_q <= in_valid;
         if (in_valid && in_ready) begin
            s1_sig_big_q      <= s1_sig_big_d;
            s1_sig_small_q    <= s1_sig_small_d;
            s1_exp_big_q      <= s1_exp_big_d;
            s1_exp_diff_q     <= s1_exp_diff_d;
            s1_sign_big_q     <= s1_sign_big_d;
            s1_eff_sub_q      <= s1_eff_sub_d;
            s1_swapped_q      <= s1_swapped_d;
            s1_special_q      <= s1_special_d;
            s1_special_sign_q <= s1_special_sign_d;
         end
      end
   end

   // Sticky collects every bit shifted past the S position.
   always_comb begin
      ext_small = {s1_sig_small_q, 3'b000};
      lost_mask = ~({SIG_W{1'b1}} << s1_exp_diff_q);
      shifted   = ext_small >> s1_exp_diff_q;
      if (int'(s1_exp_diff_q) >= SIG_W) begin
         sig_small_d = {{(SIG_W-1){1'b0}}, |s1_sig_small_q};
      end else begin
         sig_small_d = {shifted[SIG_W-1:1], shifted[0] | (|(ext_small & lost_mask))};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q    <= 1'b0;
         sig_big_q      <= '0;
         sig_small_q    <= '0;
         exp_big_q      <= '0;
         sign_big_q     <= 1'b0;
         eff_sub_q      <= 1'b0;
         swapped_q      <= 1'b0;
         special_q      <= SP_NORMAL;
         special_sign_q <= 1'b0;
      end else if (s2_can_load) begin
         out_valid_q <= s1_valid_q;
         if (s1_valid_q) begin
            sig_big_q      <= {s1_sig_big_q, 3'b000};
            sig_small_q    <= sig_small_d;
            exp_big_q      <= s1_exp_big_q;
            sign_big_q     <= s1_sign_big_q;
            eff_sub_q      <= s1_eff_sub_q;
            swapped_q      <= s1_swapped_q;
            special_q      <= s1_special_q;
            special_sign_q <= s1_special_sign_q;
         end
      end
   end

   assign out_valid    = out_valid_q;
   assign sig_big      = sig_big_q;
   assign sig_small    = sig_small_q;
   assign exp_big      = exp_big_q;
   assign sign_big     = sign_big_q;
   assign eff_sub      = eff_sub_q;
   assign swapped      = swapped_q;
   assign special      = special_q;
   assign special_sign = special_sign_q;

endmodule
